// File: rtl/ttt_pkg.sv
// Shared encodings for the tic-tac-toe turn controller: FSM states, cell and
// winner codes, and the eight winning cell triples.
package ttt_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_WAIT    = 4'd1,
    S_CHECK   = 4'd2,
    S_PLACE   = 4'd3,
    S_EVAL    = 4'd4,
    S_SWAP    = 4'd5,
    S_WIN     = 4'd6,
    S_DRAW    = 4'd7,
    S_TIMEOUT = 4'd8
  } state_t;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_X     = 2'b01;
  localparam logic [1:0] CELL_O     = 2'b10;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_X    = 2'b01;
  localparam logic [1:0] WIN_O    = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  localparam int NUM_CELLS = 9;
  localparam int NUM_LINES = 8;

  localparam int WIN_LINES [NUM_LINES][3] = '{
    '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
    '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
    '{0, 4, 8}, '{2, 4, 6}
  };

  function automatic logic [1:0] mover_code(input logic turn);
    return turn ? CELL_O : CELL_X;
  endfunction

endpackage

// File: rtl/ttt_line_check.sv
// Combinational win detector: flags when any of the eight lines is fully
// owned by the given player code.
module ttt_line_check
  import ttt_pkg::*;
(
  input  logic [17:0] board,
  input  logic [1:0]  player,
  output logic        win
);

  logic [NUM_LINES-1:0] hit;

  for (genvar l = 0; l < NUM_LINES; l++) begin : g_line
    assign hit[l] = (board[2*WIN_LINES[l][0] +: 2] == player) &&
                    (board[2*WIN_LINES[l][1] +: 2] == player) &&
                    (board[2*WIN_LINES[l][2] +: 2] == player);
  end

  assign win = |hit;

endmodule

// File: rtl/ttt_turn_controller.sv
// Tic-tac-toe game sequencer: click arbitration, board, turn timer and FSM.
// Define AUTO_PASS_EN to pass the turn on timer expiry instead of forfeiting.
module ttt_turn_controller
  import ttt_pkg::*;
#(
  parameter int TICK_DIV     = 50_000_000,
  parameter int TURN_SECONDS = 30
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        click_valid,
  input  logic [3:0]  click_cell,
  output logic        click_ready,
  output logic        illegal,
  output logic [3:0]  state,
  output logic [7:0]  Timer,
  output logic [17:0] board,
  output logic        turn,
  output logic [1:0]  winner,
  output logic [3:0]  move_count
);

  localparam int              PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [7:0]      RELOAD  = 8'(TURN_SECONDS);

  state_t        st, st_nx;
  logic [3:0]    cell_q;
  logic [PW-1:0] presc;
  logic [1:0]    mover, cur;
  logic          hs, cell_ok, line_win, expire, restart, tick;

  assign mover   = mover_code(turn);
  assign hs      = click_valid && (st == S_WAIT);
  assign expire  = (st == S_WAIT) && (Timer == 8'd0) && !hs;
  assign restart = start && ((st == S_IDLE) || (st == S_WIN) ||
                             (st == S_DRAW) || (st == S_TIMEOUT));
  assign tick    = ((st == S_WAIT) || (st == S_CHECK)) && (presc == PRE_MAX);

  always_comb begin
    cur = CELL_EMPTY;
    for (int k = 0; k < NUM_CELLS; k++)
      if (cell_q == 4'(k)) cur = board[2*k +: 2];
  end
  assign cell_ok = (cell_q <= 4'd8) && (cur == CELL_EMPTY);

  ttt_line_check u_line (
    .board  (board),
    .player (mover),
    .win    (line_win)
  );

  always_comb begin
    st_nx = st;
    case (st)
      S_IDLE, S_WIN, S_DRAW, S_TIMEOUT: if (start) st_nx = S_WAIT;
      S_WAIT: begin
        if (hs) st_nx = S_CHECK;
`ifdef AUTO_PASS_EN
        else if (expire) st_nx = S_SWAP;
`else
        else if (expire) st_nx = S_TIMEOUT;
`endif
      end
      S_CHECK: st_nx = cell_ok ? S_PLACE : S_WAIT;
      S_PLACE: st_nx = S_EVAL;
      S_EVAL: begin
        if (line_win)                st_nx = S_WIN;
        else if (move_count == 4'd9) st_nx = S_DRAW;
        else                         st_nx = S_SWAP;
      end
      S_SWAP:  st_nx = S_WAIT;
      default: st_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st         <= S_IDLE;
      cell_q     <= '0;
      presc      <= '0;
      Timer      <= RELOAD;
      board      <= '0;
      turn       <= 1'b0;
      winner     <= WIN_NONE;
      move_count <= '0;
    end else begin
      st <= st_nx;
      if (hs) cell_q <= click_cell;

      // Prescaler and timer only advance while a player is deciding.
      if (restart || st == S_SWAP)              presc <= '0;
      else if (st == S_WAIT || st == S_CHECK)   presc <= (presc == PRE_MAX) ? '0 : presc + PW'(1);

      if (restart || st == S_SWAP)              Timer <= RELOAD;
      else if (tick && Timer != 8'd0)           Timer <= Timer - 8'd1;

      if (restart) begin
        board      <= '0;
        turn       <= 1'b0;
        winner     <= WIN_NONE;
        move_count <= '0;
      end else begin
        case (st)
          S_PLACE: begin
            for (int k = 0; k < NUM_CELLS; k++)
              if (cell_q == 4'(k)) board[2*k +: 2] <= mover;
            move_count <= move_count + 4'd1;
          end
          S_EVAL: begin
            if (line_win)                winner <= mover;
            else if (move_count == 4'd9) winner <= WIN_DRAW;
          end
          S_SWAP: turn <= ~turn;
`ifndef AUTO_PASS_EN
          S_WAIT: if (expire) winner <= turn ? WIN_X : WIN_O;
`endif
          default: ;
        endcase
      end
    end
  end

  assign state       = st;
  assign click_ready = (st == S_WAIT);
  assign illegal     = (st == S_CHECK) && !cell_ok;

endmodule

// File: tb/tb_ttt_turn_controller.sv
// Directed bench for ttt_turn_controller with a scoreboard fed by a small
// independent game model.
module tb_ttt_turn_controller;
  import ttt_pkg::*;

  logic        clock, reset, start, click_valid;
  logic [3:0]  click_cell;
  logic        click_ready, illegal, turn;
  logic [3:0]  state, move_count;
  logic [7:0]  Timer;
  logic [17:0] board;
  logic [1:0]  winner;

  int checks = 0;
  int errors = 0;

  ttt_turn_controller #(.TICK_DIV(4), .TURN_SECONDS(3)) dut (
    .clock(clock), .reset(reset), .start(start),
    .click_valid(click_valid), .click_cell(click_cell),
    .click_ready(click_ready), .illegal(illegal), .state(state),
    .Timer(Timer), .board(board), .turn(turn), .winner(winner),
    .move_count(move_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  st;
    logic [17:0] brd;
    logic        trn;
    logic [1:0]  win;
    logic [3:0]  cnt;
    int          ill;
  } exp_t;

  exp_t sbq[$];

  logic [1:0] m_brd [9];
  logic       m_turn;
  logic [3:0] m_cnt;
  logic [1:0] m_win;
  logic [3:0] m_st;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] m_pack();
    logic [17:0] b = '0;
    for (int k = 0; k < 9; k++) b[2*k +: 2] = m_brd[k];
    return b;
  endfunction

  function automatic bit m_line(input logic [1:0] p);
    bit w = 0;
    for (int i = 0; i < 3; i++) begin
      if (m_brd[3*i] == p && m_brd[3*i+1] == p && m_brd[3*i+2] == p) w = 1;
      if (m_brd[i] == p && m_brd[i+3] == p && m_brd[i+6] == p) w = 1;
    end
    if (m_brd[0] == p && m_brd[4] == p && m_brd[8] == p) w = 1;
    if (m_brd[2] == p && m_brd[4] == p && m_brd[6] == p) w = 1;
    return w;
  endfunction

  task automatic m_restart();
    for (int k = 0; k < 9; k++) m_brd[k] = 2'b00;
    m_turn = 0; m_cnt = 0; m_win = 2'b00; m_st = 4'd1;
  endtask

  task automatic predict(input int c, output exp_t e);
    logic [1:0] mv;
    mv = m_turn ? 2'b10 : 2'b01;
    e.ill = 0;
    if (c > 8) e.ill = 1;
    else if (m_brd[c] != 2'b00) e.ill = 1;
    else begin
      m_brd[c] = mv;
      m_cnt = m_cnt + 4'd1;
      if (m_line(mv)) begin m_win = mv; m_st = 4'd6; end
      else if (m_cnt == 4'd9) begin m_win = 2'b11; m_st = 4'd7; end
      else m_turn = ~m_turn;
    end
    e.st = m_st; e.brd = m_pack(); e.trn = m_turn; e.win = m_win; e.cnt = m_cnt;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    m_restart();
  endtask

  // Called just after a negedge; returns at a negedge once the move settles.
  task automatic click(input int c, input bit chk_timer);
    exp_t e;
    bit   got;
    int   ill;
    predict(c, e);
    sbq.push_back(e);
    click_valid = 1'b1;
    click_cell  = 4'(c);
    got = 0;
    for (int n = 0; n < 40 && !got; n++) begin
      if (click_ready) got = 1;
      @(negedge clock);
    end
    click_valid = 1'b0;
    chk("handshake", 32'(got), 32'd1);
    ill = 0;
    for (int n = 0; n < 40; n++) begin
      ill += int'(illegal);
      if (state == S_WAIT || state >= S_WIN) break;
      @(negedge clock);
    end
    e = sbq.pop_front();
    chk($sformatf("state c%0d", c), 32'(state), 32'(e.st));
    chk($sformatf("board c%0d", c), 32'(board), 32'(e.brd));
    chk($sformatf("turn c%0d", c), 32'(turn), 32'(e.trn));
    chk($sformatf("winner c%0d", c), 32'(winner), 32'(e.win));
    chk($sformatf("count c%0d", c), 32'(move_count), 32'(e.cnt));
    chk($sformatf("illegal c%0d", c), 32'(ill), 32'(e.ill));
    if (chk_timer && e.ill == 0 && e.st == 4'd1)
      chk($sformatf("timer c%0d", c), 32'(Timer), 32'd3);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " state"}, 32'(state), 32'(S_IDLE));
    chk({tag, " board"}, 32'(board), 32'd0);
    chk({tag, " turn"}, 32'(turn), 32'd0);
    chk({tag, " winner"}, 32'(winner), 32'd0);
    chk({tag, " count"}, 32'(move_count), 32'd0);
    chk({tag, " timer"}, 32'(Timer), 32'd3);
    chk({tag, " ready"}, 32'(click_ready), 32'd0);
    chk({tag, " illegal"}, 32'(illegal), 32'd0);
  endtask

  int draw_seq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
  int win9_seq [9] = '{0, 1, 2, 4, 3, 5, 7, 8, 6};

  initial begin
    reset = 1'b0; start = 1'b0; click_valid = 1'b0; click_cell = '0;
    repeat (2) @(negedge clock);
    chk_reset_vals("por");
    reset = 1'b1;
    @(negedge clock);

    // X wins on the top row
    do_start();
    chk("start state", 32'(state), 32'(S_WAIT));
    click(0, 1); click(3, 1); click(1, 1); click(4, 1); click(2, 1);
    chk("win ready", 32'(click_ready), 32'd0);

    // Illegal clicks, then start ignored while waiting
    do_reset();
    do_start();
    click(0, 1); click(0, 0); click(12, 0); click(4, 1);
    start = 1'b1;
    repeat (2) @(negedge clock);
    start = 1'b0;
    chk("start-in-wait state", 32'(state), 32'(S_WAIT));
    chk("start-in-wait board", 32'(board), 32'(m_pack()));
    chk("start-in-wait count", 32'(move_count), 32'd2);

    // Full board, no line
    do_reset();
    do_start();
    foreach (draw_seq[i]) click(draw_seq[i], 1);

    // Ninth move completes a line: win beats draw
    do_reset();
    do_start();
    foreach (win9_seq[i]) click(win9_seq[i], 1);

    // Turn timer runs out with no clicks
    do_reset();
    do_start();
    for (int i = 1; i <= 12; i++) begin
      @(negedge clock);
      if (i % 4 == 0) chk($sformatf("timer t%0d", i), 32'(Timer), 32'(3 - i / 4));
    end
    @(negedge clock);
`ifdef AUTO_PASS_EN
    @(negedge clock);
    chk("pass state", 32'(state), 32'(S_WAIT));
    chk("pass turn", 32'(turn), 32'd1);
    chk("pass timer", 32'(Timer), 32'd3);
    chk("pass count", 32'(move_count), 32'd0);
`else
    chk("timeout state", 32'(state), 32'(S_TIMEOUT));
    chk("timeout winner", 32'(winner), 32'(WIN_O));
    chk("timeout ready", 32'(click_ready), 32'd0);
`endif

    // Click handshake on the expiry edge beats the timeout
    do_reset();
    do_start();
    repeat (12) @(negedge clock);
    chk("expiry timer", 32'(Timer), 32'd0);
    click(4, 1);

    // Asynchronous reset while a piece is being placed
    do_reset();
    do_start();
    click_valid = 1'b1;
    click_cell  = 4'd5;
    for (int n = 0; n < 20 && state != S_CHECK; n++) @(negedge clock);
    click_valid = 1'b0;
    @(negedge clock);
    chk("mid state", 32'(state), 32'(S_PLACE));
    #2 reset = 1'b0;
    #1 chk_reset_vals("async");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
